// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: flit handshake between both router input ports, the downstream link and the output-mux arbiter.
interface mux_arbiter_if #(
    parameter int TYPEW = 2
);
    logic             ivalid_0;
    logic [TYPEW-1:0] itype_0;
    logic             ivalid_1;
    logic [TYPEW-1:0] itype_1;
    logic             ordy;
    logic [1:0]       sel;
    logic             oack_0;
    logic             oack_1;
    logic             obusy;
    logic             oerr;
    modport slave (
        input  ivalid_0, itype_0, ivalid_1, itype_1, ordy,
        output sel, oack_0, oack_1, obusy, oerr
    );
    modport master (
        output ivalid_0, itype_0, ivalid_1, itype_1, ordy,
        input  sel, oack_0, oack_1, obusy, oerr
    );
endinterface

// File: rtl/mux_arbiter.sv
// mux_arbiter: packet-level round-robin lock of the 2:1 output mux, with a flit-count guard against lost tails.
module mux_arbiter #(
    parameter int               TYPEW  = 2,
    parameter logic [TYPEW-1:0] T_HEAD = 2'b01,
    parameter logic [TYPEW-1:0] T_TAIL = 2'b10,
    parameter logic [TYPEW-1:0] T_DATA = 2'b11,
    parameter int               MAXLEN = 32,
    parameter int               CNTW   = 6
) (
    input logic          clk,
    input logic          rst_,
    mux_arbiter_if.slave bus
);
    typedef enum logic {IDLE, LOCK} state_t;
    localparam logic [CNTW:0] MAX = (CNTW+1)'(MAXLEN);
    state_t           state;
    logic             prio;
    logic [CNTW-1:0]  cnt;
    logic             xfer_0, xfer_1, xfer, own;
    logic             head_0, head_1, bad_idle, win;
    logic [TYPEW-1:0] otype;
    logic [CNTW:0]    cnt_inc;
    logic             is_tail, overrun, proto;
    assign xfer_0     = bus.sel[0] & bus.ivalid_0 & bus.ordy;
    assign xfer_1     = bus.sel[1] & bus.ivalid_1 & bus.ordy;
    assign bus.oack_0 = xfer_0;
    assign bus.oack_1 = xfer_1;
    assign xfer       = xfer_0 | xfer_1;
    assign own        = bus.sel[1];
    assign otype      = own ? bus.itype_1 : bus.itype_0;
    assign head_0     = bus.ivalid_0 & (bus.itype_0 == T_HEAD);
    assign head_1     = bus.ivalid_1 & (bus.itype_1 == T_HEAD);
    // Anything but a HEAD arriving while no packet owns the output is a protocol error.
    assign bad_idle   = (bus.ivalid_0 & (bus.itype_0 inside {T_DATA, T_TAIL, '0})) |
                        (bus.ivalid_1 & (bus.itype_1 inside {T_DATA, T_TAIL, '0}));
    assign win        = (head_0 & head_1) ? prio : head_1;
    assign cnt_inc    = {1'b0, cnt} + 1'b1;
    assign is_tail    = otype == T_TAIL;
    assign overrun    = !is_tail && cnt_inc == MAX;
    assign proto      = otype == T_HEAD && cnt != '0;
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            bus.sel   <= 2'b00;
            bus.obusy <= 1'b0;
            bus.oerr  <= 1'b0;
            cnt       <= '0;
            prio      <= 1'b0;
        end else if (state == IDLE) begin
            if (bad_idle) bus.oerr <= 1'b1;
            if (head_0 | head_1) begin
                bus.sel   <= win ? 2'b10 : 2'b01;
                bus.obusy <= 1'b1;
                cnt       <= '0;
                state     <= LOCK;
            end
        end else if (xfer) begin
            cnt <= &cnt ? cnt : cnt_inc[CNTW-1:0];
            if (proto || overrun) bus.oerr <= 1'b1;
            // A missing TAIL is treated as if the MAXLEN-th flit were the TAIL.
            if (is_tail || overrun) begin
                bus.sel   <= 2'b00;
                bus.obusy <= 1'b0;
                prio      <= ~own;
                state     <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: scoreboard bench; per-port flit sources feed the arbiter, expected grant order is queued up front.
module tb_mux_arbiter;
    localparam logic [1:0] H = 2'b01, T = 2'b10, D = 2'b11;
    typedef struct {
        int         port;
        logic [1:0] typ;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       rdy = 1'b1;
    logic [1:0] src0[$], src1[$];
    exp_t       sb[$];
    logic [1:0] prev_sel = 2'b00;
    int         checks = 0, errors = 0, ack_cnt = 0;
    always #5 clk = ~clk;
    mux_arbiter_if #(.TYPEW(2)) bus();
    mux_arbiter #(.TYPEW(2), .T_HEAD(H), .T_TAIL(T), .T_DATA(D), .MAXLEN(32), .CNTW(6))
        dut (.clk(clk), .rst_(rst_), .bus(bus));
    task automatic pkt(input int port, input int ndata, input bit tail, input int nexp);
        logic [1:0] f[$];
        f.push_back(H);
        for (int i = 0; i < ndata; i++) f.push_back(D);
        if (tail) f.push_back(T);
        for (int i = 0; i < f.size(); i++) begin
            if (port == 0) src0.push_back(f[i]);
            else src1.push_back(f[i]);
            if (i < nexp) sb.push_back('{port, f[i]});
        end
    endtask
    task automatic step();
        int         p;
        logic [1:0] ty;
        exp_t       e;
        @(negedge clk);
        bus.ordy     = rdy;
        bus.ivalid_0 = src0.size() != 0;
        bus.itype_0  = src0.size() != 0 ? src0[0] : 2'b00;
        bus.ivalid_1 = src1.size() != 0;
        bus.itype_1  = src1.size() != 0 ? src1[0] : 2'b00;
        #1;
        if (bus.oack_0 || bus.oack_1) begin
            p  = bus.oack_1 ? 1 : 0;
            ty = p ? src1[0] : src0[0];
            checks++;
            if (bus.oack_0 && bus.oack_1) begin
                errors++;
                $display("FAIL dual_ack: oack_0=1 oack_1=1, want at most one");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: port %0d type %b acked, scoreboard empty", p, ty);
            end else begin
                e = sb.pop_front();
                if (e.port !== p || e.typ !== ty) begin
                    errors++;
                    $display("FAIL ack_order: got port %0d type %b, want port %0d type %b", p, ty, e.port, e.typ);
                end
            end
            if (p) void'(src1.pop_front());
            else void'(src0.pop_front());
            ack_cnt++;
        end
        if (prev_sel != 2'b00 && bus.sel != 2'b00) begin
            checks++;
            if (bus.sel !== prev_sel) begin
                errors++;
                $display("FAIL sel_switch: sel=%b, want %b (no idle cycle)", bus.sel, prev_sel);
            end
        end
        prev_sel = bus.sel;
    endtask
    task automatic run_until(input int target, input int bound);
        int n = 0;
        while (ack_cnt < target && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (ack_cnt < target) begin
            errors++;
            $display("FAIL timeout: acks=%0d, want %0d within %0d cycles", ack_cnt, target, bound);
        end
    endtask
    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0;
        src0.delete();
        src1.delete();
        sb.delete();
        {bus.ivalid_0, bus.itype_0, bus.ivalid_1, bus.itype_1} = '0;
        rdy = 1'b1;
        bus.ordy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        ack_cnt = 0;
        prev_sel = 2'b00;
    endtask
    task automatic test_reset();
        bus.ivalid_0 = 1'b1;
        bus.itype_0  = H;
        bus.ivalid_1 = 1'b1;
        bus.itype_1  = H;
        bus.ordy     = 1'b1;
        #2 rst_ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", bus.sel, 2'b00);
        chk("rst_oack_0", {1'b0, bus.oack_0}, 2'b00);
        chk("rst_oack_1", {1'b0, bus.oack_1}, 2'b00);
        chk("rst_obusy", {1'b0, bus.obusy}, 2'b00);
        chk("rst_oerr", {1'b0, bus.oerr}, 2'b00);
    endtask
    task automatic test_single();
        do_reset();
        pkt(1, 18, 1, 20);
        step();
        chk("single_latency_sel", bus.sel, 2'b00);
        step();
        chk("single_sel", bus.sel, 2'b10);
        chk("single_obusy", {1'b0, bus.obusy}, 2'b01);
        run_until(20, 100);
        step();
        chk("single_release_sel", bus.sel, 2'b00);
        chk("single_release_obusy", {1'b0, bus.obusy}, 2'b00);
        chk("single_oerr", {1'b0, bus.oerr}, 2'b00);
        chk("single_acks", ack_cnt[1:0], 2'(20));
    endtask
    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pkt(0, 2, 1, 4);
            pkt(1, 2, 1, 4);
        end
        step();
        chk("cont_latency_sel", bus.sel, 2'b00);
        step();
        chk("cont_first_winner", bus.sel, 2'b01);
        run_until(40, 400);
        step();
        chk("cont_final_sel", bus.sel, 2'b00);
        chk("cont_oerr", {1'b0, bus.oerr}, 2'b00);
    endtask
    task automatic test_backpressure();
        do_reset();
        pkt(0, 18, 1, 20);
        run_until(5, 50);
        rdy = 1'b0;
        repeat (3) step();
        chk("bp_no_acks", ack_cnt[1:0], 2'(5));
        chk("bp_sel_held", bus.sel, 2'b01);
        checks++;
        if (dut.cnt !== 6'd5) begin
            errors++;
            $display("FAIL bp_cnt: got %0d, want 5", dut.cnt);
        end
        rdy = 1'b1;
        run_until(20, 100);
        step();
        chk("bp_release_sel", bus.sel, 2'b00);
        chk("bp_oerr", {1'b0, bus.oerr}, 2'b00);
    endtask
    task automatic test_overrun();
        do_reset();
        pkt(0, 40, 0, 32);
        pkt(1, 0, 1, 2);
        run_until(31, 100);
        chk("ovr_oerr_before", {1'b0, bus.oerr}, 2'b00);
        chk("ovr_sel_before", bus.sel, 2'b01);
        step();
        chk("ovr_32nd_ack", {1'b0, bus.oack_0}, 2'b01);
        step();
        chk("ovr_oerr", {1'b0, bus.oerr}, 2'b01);
        chk("ovr_release_sel", bus.sel, 2'b00);
        step();
        chk("ovr_port1_granted", bus.sel, 2'b10);
        run_until(34, 20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ovr_scoreboard: %0d flits left, want 0", sb.size());
        end
    endtask
    task automatic test_protocol();
        do_reset();
        src0.push_back(D);
        step();
        chk("proto_no_ack", {1'b0, bus.oack_0}, 2'b00);
        step();
        chk("proto_oerr", {1'b0, bus.oerr}, 2'b01);
        chk("proto_sel", bus.sel, 2'b00);
        do_reset();
        chk("proto_oerr_cleared", {1'b0, bus.oerr}, 2'b00);
    endtask
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overrun();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
